// File: rtl/arith_unit_pkg.sv
// Shared arithmetic definitions: datapath width, ALU opcodes and the EX control bundle layout.
package arith_unit_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ALUOP_W = 4;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [ALUOP_W-1:0] ALUOP_AND  = 4'b0000;
    localparam logic [ALUOP_W-1:0] ALUOP_OR   = 4'b0001;
    localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 4'b0010;
    localparam logic [ALUOP_W-1:0] ALUOP_XOR  = 4'b0011;
    localparam logic [ALUOP_W-1:0] ALUOP_NOR  = 4'b0100;
    localparam logic [ALUOP_W-1:0] ALUOP_SLTU = 4'b0101;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB  = 4'b0110;
    localparam logic [ALUOP_W-1:0] ALUOP_SLT  = 4'b0111;
    localparam logic [ALUOP_W-1:0] ALUOP_SLL  = 4'b1000;
    localparam logic [ALUOP_W-1:0] ALUOP_SRL  = 4'b1001;
    localparam logic [ALUOP_W-1:0] ALUOP_SRA  = 4'b1010;
    localparam logic [ALUOP_W-1:0] ALUOP_LUI  = 4'b1011;

    // EX-stage control bundle; alu_op sits at bits [EX_ALUOP_LSB +: ALUOP_W].
    typedef struct packed {
        logic               reg_write;
        logic               mem_to_reg;
        logic               mem_write;
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic               reg_dst;
    } ex_ctrl_t;

    localparam int unsigned EX_ALUOP_LSB = 2;
    localparam int unsigned EX_CTRL_W    = $bits(ex_ctrl_t);

    function automatic logic [ALUOP_W-1:0] ex_alu_op(input ex_ctrl_t ctrl);
        return ctrl.alu_op;
    endfunction

endpackage

// File: rtl/arith_unit_alu_core.sv
// Combinational ALU: result, zero detect and signed overflow for ADD/SUB.
module arith_unit_alu_core
    import arith_unit_pkg::*;
(
    input  logic [DATA_W-1:0]  src_a,
    input  logic [DATA_W-1:0]  src_b,
    input  logic [ALUOP_W-1:0] alu_op,
    output logic [DATA_W-1:0]  alu_out,
    output logic               zero,
    output logic               overflow
);

    logic [DATA_W-1:0]  sum;
    logic [DATA_W-1:0]  diff;
    logic [SHAMT_W-1:0] shamt;
    logic               add_ovf;
    logic               sub_ovf;
    logic               lt_signed;
    logic               lt_unsigned;

    assign sum   = src_a + src_b;
    assign diff  = src_a - src_b;
    assign shamt = src_b[SHAMT_W-1:0];

    assign add_ovf = (src_a[DATA_W-1] == src_b[DATA_W-1]) && (sum[DATA_W-1] != src_a[DATA_W-1]);
    assign sub_ovf = (src_a[DATA_W-1] != src_b[DATA_W-1]) && (diff[DATA_W-1] != src_a[DATA_W-1]);

    // Sign of the difference corrected by overflow keeps SLT right across the full range.
    assign lt_signed   = diff[DATA_W-1] ^ sub_ovf;
    assign lt_unsigned = src_a < src_b;

    always_comb begin
        alu_out  = '0;
        overflow = 1'b0;
        case (alu_op)
            ALUOP_AND:  alu_out = src_a & src_b;
            ALUOP_OR:   alu_out = src_a | src_b;
            ALUOP_ADD: begin
                alu_out  = sum;
                overflow = add_ovf;
            end
            ALUOP_XOR:  alu_out = src_a ^ src_b;
            ALUOP_NOR:  alu_out = ~(src_a | src_b);
            ALUOP_SLTU: alu_out = DATA_W'(lt_unsigned);
            ALUOP_SUB: begin
                alu_out  = diff;
                overflow = sub_ovf;
            end
            ALUOP_SLT:  alu_out = DATA_W'(lt_signed);
            ALUOP_SLL:  alu_out = src_a << shamt;
            ALUOP_SRL:  alu_out = src_a >> shamt;
            ALUOP_SRA:  alu_out = DATA_W'($signed(src_a) >>> shamt);
            ALUOP_LUI:  alu_out = {src_b[15:0], 16'h0000};
            default: begin
                alu_out  = '0;
                overflow = 1'b0;
            end
        endcase
    end

    assign zero = (alu_out == '0);

endmodule

// File: rtl/arith_unit.sv
// Pipeline arithmetic block: PC+4 incrementer, branch-target adder, execute ALU and sticky overflow flag.
module arith_unit
    import arith_unit_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  src_a,
    input  logic [DATA_W-1:0]  src_b,
    input  logic [ALUOP_W-1:0] alu_op,
    output logic [DATA_W-1:0]  alu_out,
    output logic               zero,
    output logic               overflow,
    output logic               ovf_sticky,
    input  logic [DATA_W-1:0]  pc_f,
    output logic [DATA_W-1:0]  pc_plus4,
    input  logic [DATA_W-1:0]  pc_plus4_d,
    input  logic [DATA_W-1:0]  sign_imm,
    output logic [DATA_W-1:0]  branch_target
);

    arith_unit_alu_core u_alu_core (
        .src_a    (src_a),
        .src_b    (src_b),
        .alu_op   (alu_op),
        .alu_out  (alu_out),
        .zero     (zero),
        .overflow (overflow)
    );

    // Fetch and decode adders; both wrap mod 2^32.
    assign pc_plus4      = pc_f + DATA_W'(4);
    assign branch_target = pc_plus4_d + (sign_imm << 2);

    // Reset wins over a same-cycle overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_sticky <= 1'b0;
        end else begin
            ovf_sticky <= ovf_sticky | overflow;
        end
    end

endmodule

// File: tb/tb_arith_unit.sv
// Randomized scoreboard bench for arith_unit against a plain-arithmetic reference model.
module tb_arith_unit;

    typedef struct {
        string       tag;
        logic [31:0] alu_out;
        logic        zero;
        logic        overflow;
        logic        ovf_sticky;
        logic [31:0] pc_plus4;
        logic [31:0] branch_target;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic [3:0]  alu_op = '0;
    logic [31:0] alu_out;
    logic        zero;
    logic        overflow;
    logic        ovf_sticky;
    logic [31:0] pc_f = '0;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus4_d = '0;
    logic [31:0] sign_imm = '0;
    logic [31:0] branch_target;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   issued = 0;
    int   popped = 0;

    // Model state describing what was presented during the previous cycle.
    logic m_sticky   = 1'b0;
    logic m_prev_rst = 1'b1;
    logic m_prev_ovf = 1'b0;

    arith_unit dut (
        .clk           (clk),
        .reset         (reset),
        .src_a         (src_a),
        .src_b         (src_b),
        .alu_op        (alu_op),
        .alu_out       (alu_out),
        .zero          (zero),
        .overflow      (overflow),
        .ovf_sticky    (ovf_sticky),
        .pc_f          (pc_f),
        .pc_plus4      (pc_plus4),
        .pc_plus4_d    (pc_plus4_d),
        .sign_imm      (sign_imm),
        .branch_target (branch_target)
    );

    always #5 clk = ~clk;

    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic ovf);
        longint sa, sb, wide;
        int     sh;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sh  = int'(b % 32);
        res = 32'h0;
        ovf = 1'b0;
        case (op)
            4'd0:  res = a & b;
            4'd1:  res = a | b;
            4'd2: begin
                wide = sa + sb;
                res  = 32'(wide);
                ovf  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'd3:  res = a ^ b;
            4'd4:  res = ~(a | b);
            4'd5:  res = (a < b) ? 32'd1 : 32'd0;
            4'd6: begin
                wide = sa - sb;
                res  = 32'(wide);
                ovf  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'd7:  res = (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  res = 32'(longint'(a) * (64'd1 << sh));
            4'd9:  res = 32'(longint'(a) / (64'd1 << sh));
            4'd10: begin
                res = a;
                for (int i = 0; i < sh; i++) res = {res[31], res[31:1]};
            end
            4'd11: res = (b % 32'h10000) * 32'h10000;
            default: res = 32'h0;
        endcase
    endfunction

    task automatic drive(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pcf, input logic [31:0] pcd, input logic [31:0] imm,
                         input logic rst);
        exp_t        e;
        logic [31:0] r;
        logic        o;
        @(posedge clk);
        m_sticky = m_prev_rst ? 1'b0 : (m_sticky | m_prev_ovf);
        #1;
        alu_op = op; src_a = a; src_b = b;
        pc_f = pcf; pc_plus4_d = pcd; sign_imm = imm; reset = rst;
        ref_alu(op, a, b, r, o);
        e.tag           = tag;
        e.alu_out       = r;
        e.zero          = (r == 32'h0);
        e.overflow      = o;
        e.ovf_sticky    = m_sticky;
        e.pc_plus4      = pcf + 32'd4;
        e.branch_target = pcd + imm * 32'd4;
        q.push_back(e);
        issued++;
        m_prev_rst = rst;
        m_prev_ovf = o;
    endtask

    task automatic chk(input string name, input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %h expected %h at %0t", tag, name, act, exp, $time);
        end
    endtask

    // Monitor: every presented vector is checked mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            popped++;
            chk("alu_out",       e.tag, alu_out,              e.alu_out);
            chk("zero",          e.tag, 32'(zero),            32'(e.zero));
            chk("overflow",      e.tag, 32'(overflow),        32'(e.overflow));
            chk("ovf_sticky",    e.tag, 32'(ovf_sticky),      32'(e.ovf_sticky));
            chk("pc_plus4",      e.tag, pc_plus4,             e.pc_plus4);
            chk("branch_target", e.tag, branch_target,        e.branch_target);
        end
    end

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h00000000;
            4: return 32'(signed'($urandom_range(0, 8)) - 4);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int budget;
        drive("rst0",   4'd0,  32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        drive("rst1",   4'd0,  32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        drive("add_ov", 4'd2,  32'h7FFFFFFF, 32'h1, 32'h00400000, 32'h00400010, 32'hFFFFFFFE, 1'b0);
        drive("sub_eq", 4'd6,  32'd5, 32'd5, 32'hFFFFFFFC, 32'h00400010, 32'd3, 1'b0);
        drive("slt",    4'd7,  32'h80000000, 32'h1, 32'h0, 32'h0, 32'h0, 1'b0);
        drive("sltu",   4'd5,  32'h80000000, 32'h1, 32'h0, 32'h0, 32'h0, 1'b0);
        drive("sra",    4'd10, 32'hF0000000, 32'h24, 32'h0, 32'h0, 32'h0, 1'b0);
        drive("srl",    4'd9,  32'hF0000000, 32'h24, 32'h0, 32'h0, 32'h0, 1'b0);
        drive("sll",    4'd8,  32'h1, 32'd31, 32'h0, 32'h0, 32'h0, 1'b1);
        drive("lui",    4'd11, 32'h0, 32'h1234ABCD, 32'h0, 32'h0, 32'h0, 1'b0);
        drive("nor",    4'd4,  32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        drive("op15",   4'd15, 32'hDEADBEEF, 32'h12345678, 32'h0, 32'h0, 32'h0, 1'b0);
        drive("sub_ov", 4'd6,  32'h80000000, 32'h1, 32'h0, 32'h0, 32'h0, 1'b1);
        drive("rst_ov", 4'd0,  32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            drive("rand", 4'($urandom_range(0, 15)), rnd_operand(), rnd_operand(),
                  $urandom, $urandom, rnd_operand(), ($urandom_range(0, 19) == 0));
        end
        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        checks++;
        if (q.size() != 0 || popped != issued) begin
            errors++;
            $display("FAIL drain: checked %0d vectors, issued %0d", popped, issued);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
